// File: rtl/cpu_isa_pkg.sv
// ISA constants shared by the control unit: opcode/extension encodings, branch
// conditions, FSM state encoding and PSR flag bit positions.
package cpu_isa_pkg;

  localparam logic [3:0] OP_RR  = 4'h0;
  localparam logic [3:0] OP_MEM = 4'h4;
  localparam logic [3:0] OP_BCC = 4'hC;

  localparam logic [3:0] EXT_LOAD = 4'h0;
  localparam logic [3:0] EXT_STOR = 4'h4;

  // ALU codes share one encoding between RR opext and immediate op fields
  localparam logic [3:0] ALU_AND = 4'h1;
  localparam logic [3:0] ALU_OR  = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;
  localparam logic [3:0] ALU_ADD = 4'h5;
  localparam logic [3:0] ALU_SUB = 4'h9;
  localparam logic [3:0] ALU_CMP = 4'hB;
  localparam logic [3:0] ALU_MOV = 4'hD;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_HI = 4'h4;
  localparam logic [3:0] COND_LS = 4'h5;
  localparam logic [3:0] COND_GT = 4'h6;
  localparam logic [3:0] COND_LE = 4'h7;
  localparam logic [3:0] COND_UC = 4'hE;

  localparam int unsigned FLAG_N = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_F = 2;
  localparam int unsigned FLAG_L = 3;
  localparam int unsigned FLAG_C = 4;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_LDWB,
    S_HALT
  } state_e;

  function automatic logic is_alu_code(input logic [3:0] code);
    return (code == ALU_AND) || (code == ALU_OR)  || (code == ALU_XOR) ||
           (code == ALU_ADD) || (code == ALU_SUB) || (code == ALU_CMP) ||
           (code == ALU_MOV);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Branch condition evaluator: decides whether a Bcond is taken from the
// architectural flag register only.
module branch_cond_eval
  import cpu_isa_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [4:0] i_psr,
  output logic       o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      COND_EQ: o_taken = i_psr[FLAG_Z];
      COND_NE: o_taken = ~i_psr[FLAG_Z];
      COND_CS: o_taken = i_psr[FLAG_C];
      COND_CC: o_taken = ~i_psr[FLAG_C];
      COND_HI: o_taken = i_psr[FLAG_L];
      COND_LS: o_taken = ~i_psr[FLAG_L];
      COND_GT: o_taken = i_psr[FLAG_N];
      COND_LE: o_taken = ~i_psr[FLAG_N];
      COND_UC: o_taken = 1'b1;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit: fetch, decode, execute (plus load write-back and
// halt). Outputs are Moore-decoded from the state and the latched IR.
module cpu_control_fsm
  import cpu_isa_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 16,
  parameter int unsigned OPC_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ram_out,
  input  logic [4:0]        Flags_out,
  output logic [NREG-1:0]   wEnable,
  output logic [OPC_W-1:0]  opcode,
  output logic [3:0]        Rdest_select,
  output logic [3:0]        Rsrc_select,
  output logic [DATA_W-1:0] Imm_in,
  output logic              Imm_select,
  output logic              en_a,
  output logic              ram_we,
  output logic              lsc_mux_selct,
  output logic              fsm_alu_mem_selct,
  output logic              pc_en,
  output logic              pc_mux_selct,
  output logic [DATA_W-1:0] pc_add_k,
  output logic              halted
);

  state_e            r_state, w_state_next;
  logic [DATA_W-1:0] r_ir;
  logic [4:0]        r_psr;

  logic [3:0]        w_op, w_opext, w_rd, w_rs, w_alu_code;
  logic              w_is_wait, w_is_rr, w_is_imm, w_is_alu, w_is_load, w_is_stor, w_is_bcc;
  logic              w_alu_writes, w_alu_sets_psr, w_imm_signed, w_taken;
  logic [NREG-1:0]   w_rd_onehot;
  logic [DATA_W-1:0] w_imm_sext, w_imm_zext;

  assign w_op    = r_ir[15:12];
  assign w_rd    = r_ir[11:8];
  assign w_opext = r_ir[7:4];
  assign w_rs    = r_ir[3:0];

  assign w_is_wait = (r_ir == '0);
  assign w_is_rr   = (w_op == OP_RR) && is_alu_code(w_opext);
  assign w_is_imm  = is_alu_code(w_op);
  assign w_is_alu  = w_is_rr || w_is_imm;
  assign w_is_load = (w_op == OP_MEM) && (w_opext == EXT_LOAD);
  assign w_is_stor = (w_op == OP_MEM) && (w_opext == EXT_STOR);
  assign w_is_bcc  = (w_op == OP_BCC);

  assign w_alu_code     = w_is_rr ? w_opext : w_op;
  assign w_alu_writes   = (w_alu_code != ALU_CMP);
  assign w_alu_sets_psr = (w_alu_code != ALU_MOV);
  assign w_imm_signed   = (w_alu_code == ALU_ADD) || (w_alu_code == ALU_SUB) ||
                          (w_alu_code == ALU_CMP);

  assign w_rd_onehot = NREG'(1) << w_rd;
  assign w_imm_sext  = {{(DATA_W-8){r_ir[7]}}, r_ir[7:0]};
  assign w_imm_zext  = {{(DATA_W-8){1'b0}}, r_ir[7:0]};

  branch_cond_eval u_branch_cond_eval (
    .i_cond  (w_rd),
    .i_psr   (r_psr),
    .o_taken (w_taken)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_ir    <= '0;
      r_psr   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_DECODE) begin
        r_ir <= ram_out;
      end
      if ((r_state == S_EXEC) && w_is_alu && w_alu_sets_psr) begin
        r_psr <= Flags_out;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH:  w_state_next = S_DECODE;
      S_DECODE: w_state_next = S_EXEC;
      S_EXEC: begin
        if (w_is_wait) begin
          w_state_next = S_HALT;
        end else if (w_is_load) begin
          w_state_next = S_LDWB;
        end else begin
          w_state_next = S_FETCH;
        end
      end
      S_LDWB:   w_state_next = S_FETCH;
      S_HALT:   w_state_next = S_HALT;
      default:  w_state_next = S_FETCH;
    endcase
  end

  always_comb begin
    wEnable           = '0;
    opcode            = '0;
    Rdest_select      = '0;
    Rsrc_select       = '0;
    Imm_in            = '0;
    Imm_select        = 1'b0;
    en_a              = 1'b0;
    ram_we            = 1'b0;
    lsc_mux_selct     = 1'b0;
    fsm_alu_mem_selct = 1'b0;
    pc_en             = 1'b0;
    pc_mux_selct      = 1'b0;
    pc_add_k          = '0;
    halted            = 1'b0;
    case (r_state)
      S_FETCH: en_a = 1'b1;
      S_EXEC: begin
        if (w_is_wait) begin
          pc_en = 1'b0;
        end else if (w_is_alu) begin
          Rdest_select = w_rd;
          if (w_is_rr) begin
            Rsrc_select = w_rs;
            opcode      = OPC_W'({w_op, w_opext});
          end else begin
            Imm_select = 1'b1;
            Imm_in     = w_imm_signed ? w_imm_sext : w_imm_zext;
            opcode     = OPC_W'({w_op, 4'h0});
          end
          if (w_alu_writes) begin
            wEnable = w_rd_onehot;
          end
          pc_en = 1'b1;
        end else if (w_is_load) begin
          Rdest_select  = w_rs;
          lsc_mux_selct = 1'b1;
          en_a          = 1'b1;
        end else if (w_is_stor) begin
          Rdest_select  = w_rs;
          Rsrc_select   = w_rd;
          lsc_mux_selct = 1'b1;
          en_a          = 1'b1;
          ram_we        = 1'b1;
          pc_en         = 1'b1;
        end else if (w_is_bcc) begin
          pc_add_k     = w_imm_sext;
          pc_mux_selct = w_taken;
          pc_en        = 1'b1;
        end else begin
          pc_en = 1'b1;
        end
      end
      S_LDWB: begin
        fsm_alu_mem_selct = 1'b1;
        wEnable           = w_rd_onehot;
        pc_en             = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: drives each instruction word on ram_out
// and checks the execute-cycle control outputs against hand-computed values.
module tb_cpu_control_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] ram_out = '0;
  logic [4:0]  Flags_out = '0;
  logic [15:0] wEnable, Imm_in, pc_add_k;
  logic [7:0]  opcode;
  logic [3:0]  Rdest_select, Rsrc_select;
  logic        Imm_select, en_a, ram_we, lsc_mux_selct, fsm_alu_mem_selct;
  logic        pc_en, pc_mux_selct, halted;

  int n_checks = 0;
  int n_errors = 0;

  cpu_control_fsm dut (
    .clk               (clk),
    .reset             (reset),
    .ram_out           (ram_out),
    .Flags_out         (Flags_out),
    .wEnable           (wEnable),
    .opcode            (opcode),
    .Rdest_select      (Rdest_select),
    .Rsrc_select       (Rsrc_select),
    .Imm_in            (Imm_in),
    .Imm_select        (Imm_select),
    .en_a              (en_a),
    .ram_we            (ram_we),
    .lsc_mux_selct     (lsc_mux_selct),
    .fsm_alu_mem_selct (fsm_alu_mem_selct),
    .pc_en             (pc_en),
    .pc_mux_selct      (pc_mux_selct),
    .pc_add_k          (pc_add_k),
    .halted            (halted)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in S_FETCH; returns sampled in S_EXEC of the given instruction.
  task automatic exec_to(input logic [15:0] instr, input logic [4:0] flags);
    check_eq("fetch_en_a", en_a, 1'b1);
    check_eq("fetch_pc_en", pc_en, 1'b0);
    ram_out   = instr;
    Flags_out = flags;
    step();
    step();
  endtask

  initial begin
    int bad;
    repeat (2) step();
    check_eq("rst_wen", wEnable, 16'h0);
    check_eq("rst_opcode", opcode, 8'h0);
    check_eq("rst_en_a", en_a, 1'b1);
    check_eq("rst_lsc", lsc_mux_selct, 1'b0);
    check_eq("rst_ram_we", ram_we, 1'b0);
    check_eq("rst_pc_en", pc_en, 1'b0);
    check_eq("rst_halted", halted, 1'b0);
    check_eq("rst_imm_sel", Imm_select, 1'b0);
    check_eq("rst_psr", dut.r_psr, 5'h0);
    reset = 1'b1;

    exec_to(16'h0152, 5'b00010);
    check_eq("add_wen", wEnable, 16'h0002);
    check_eq("add_opcode", opcode, 8'h05);
    check_eq("add_rdest", Rdest_select, 4'd1);
    check_eq("add_rsrc", Rsrc_select, 4'd2);
    check_eq("add_imm_sel", Imm_select, 1'b0);
    check_eq("add_pc_en", pc_en, 1'b1);
    check_eq("add_pc_mux", pc_mux_selct, 1'b0);
    step();
    check_eq("add_psr", dut.r_psr, 5'h02);

    // Z comes from PSR; same-cycle Flags_out is all zero
    exec_to(16'hC0FE, 5'b00000);
    check_eq("beq_t_mux", pc_mux_selct, 1'b1);
    check_eq("beq_t_k", pc_add_k, 16'hFFFE);
    check_eq("beq_t_pc_en", pc_en, 1'b1);
    step();

    exec_to(16'hB3FF, 5'b00001);
    check_eq("cmpi_imm", Imm_in, 16'hFFFF);
    check_eq("cmpi_imm_sel", Imm_select, 1'b1);
    check_eq("cmpi_wen", wEnable, 16'h0);
    check_eq("cmpi_opcode", opcode, 8'hB0);
    check_eq("cmpi_rdest", Rdest_select, 4'd3);
    step();
    check_eq("cmpi_psr", dut.r_psr, 5'h01);

    exec_to(16'hC0FE, 5'b00010);
    check_eq("beq_nt_mux", pc_mux_selct, 1'b0);
    check_eq("beq_nt_pc_en", pc_en, 1'b1);
    step();

    exec_to(16'hC602, 5'b00000);
    check_eq("bgt_mux", pc_mux_selct, 1'b1);
    check_eq("bgt_k", pc_add_k, 16'h0002);
    step();

    exec_to(16'hC805, 5'b11111);
    check_eq("bc8_mux", pc_mux_selct, 1'b0);
    check_eq("bc8_pc_en", pc_en, 1'b1);
    step();

    exec_to(16'hD1FF, 5'b11111);
    check_eq("movi_imm", Imm_in, 16'h00FF);
    check_eq("movi_wen", wEnable, 16'h0002);
    check_eq("movi_opcode", opcode, 8'hD0);
    step();
    check_eq("movi_psr", dut.r_psr, 5'h01);

    exec_to(16'hCEFF, 5'b00000);
    check_eq("buc_mux", pc_mux_selct, 1'b1);
    check_eq("buc_k", pc_add_k, 16'hFFFF);
    step();

    exec_to(16'h4506, 5'b00000);
    check_eq("ld_lsc", lsc_mux_selct, 1'b1);
    check_eq("ld_rdest", Rdest_select, 4'd6);
    check_eq("ld_en_a", en_a, 1'b1);
    check_eq("ld_ex_wen", wEnable, 16'h0);
    check_eq("ld_ex_pc_en", pc_en, 1'b0);
    step();
    check_eq("ldwb_sel", fsm_alu_mem_selct, 1'b1);
    check_eq("ldwb_wen", wEnable, 16'h0020);
    check_eq("ldwb_pc_en", pc_en, 1'b1);
    step();

    exec_to(16'h4746, 5'b00000);
    check_eq("st_we", ram_we, 1'b1);
    check_eq("st_rdest", Rdest_select, 4'd6);
    check_eq("st_rsrc", Rsrc_select, 4'd7);
    check_eq("st_wen", wEnable, 16'h0);
    check_eq("st_lsc", lsc_mux_selct, 1'b1);
    check_eq("st_pc_en", pc_en, 1'b1);
    step();
    check_eq("st_we_off", ram_we, 1'b0);

    exec_to(16'h0F80, 5'b11111);
    check_eq("nop_pc_en", pc_en, 1'b1);
    check_eq("nop_wen", wEnable, 16'h0);
    step();
    check_eq("nop_psr", dut.r_psr, 5'h01);

    exec_to(16'h0152, 5'b10000);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_wen", wEnable, 16'h0);
    check_eq("mid_rst_en_a", en_a, 1'b1);
    check_eq("mid_rst_pc_en", pc_en, 1'b0);
    check_eq("mid_rst_opcode", opcode, 8'h0);
    step();
    check_eq("mid_rst_psr", dut.r_psr, 5'h0);
    reset = 1'b1;

    exec_to(16'h0000, 5'b00000);
    check_eq("wait_pc_en", pc_en, 1'b0);
    step();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (pc_en !== 1'b0 || halted !== 1'b1 || en_a !== 1'b0) bad++;
      step();
    end
    check_eq("halt_hold", bad, 0);
    reset = 1'b0;
    #1;
    check_eq("halt_rst", halted, 1'b0);
    step();
    reset = 1'b1;
    exec_to(16'h0152, 5'b00000);
    check_eq("resume_wen", wEnable, 16'h0002);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
